char_key_ctrl: RTL and testbench

Receives PS/2 keyboard frames on a single system clock and decodes make/break scan codes into held-key levels. Drives the `stepleft`, `stepright` and `stepjump` inputs of `draw_char`, so it is the producer side of the character-movement command interface. The block contains a bit-level frame receiver, a prefix-tracking decoder and per-key hold registers.

---
 rtl/ps2_pkg.sv | 61 ++++++
 rtl/char_key_ctrl_if.sv | 37 +++
 rtl/ps2_rx.sv | 112 +++++++++++
 rtl/char_key_ctrl.sv | 98 +++++++++
 tb/tb_char_key_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, key slot indices and receiver state type
// for the PS/2 character-movement controller.
package ps2_pkg;

  typedef logic [7:0] sc_t;

  localparam sc_t SC_EXT    = 8'hE0;
  localparam sc_t SC_BRK    = 8'hF0;
  localparam sc_t SC_A      = 8'h1C;
  localparam sc_t SC_D      = 8'h23;
  localparam sc_t SC_W      = 8'h1D;
  localparam sc_t SC_SPACE  = 8'h29;
  localparam sc_t SC_LARROW = 8'h6B;
  localparam sc_t SC_RARROW = 8'h74;
  localparam sc_t SC_UARROW = 8'h75;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  // One hold flag per physical key, so that extended and
  // plain variants release independently.
  localparam int        NKEY   = 7;
  localparam logic [2:0] K_A    = 3'd0;
  localparam logic [2:0] K_LA   = 3'd1;
  localparam logic [2:0] K_D    = 3'd2;
  localparam logic [2:0] K_RA   = 3'd3;
  localparam logic [2:0] K_W    = 3'd4;
  localparam logic [2:0] K_SP   = 3'd5;
  localparam logic [2:0] K_UA   = 3'd6;
  localparam logic [2:0] K_NONE = 3'd7;

  function automatic logic [2:0] key_idx(
    input logic ext,
    input sc_t  code
  );
    logic [2:0] k;
    k = K_NONE;
    if (!ext) begin
      case (code)
        SC_A:     k = K_A;
        SC_D:     k = K_D;
        SC_W:     k = K_W;
        SC_SPACE: k = K_SP;
        default:  k = K_NONE;
      endcase
    end else begin
      case (code)
        SC_LARROW: k = K_LA;
        SC_RARROW: k = K_RA;
        SC_UARROW: k = K_UA;
        default:   k = K_NONE;
      endcase
    end
    return k;
  endfunction

endpackage

// File: rtl/char_key_ctrl_if.sv
// PS/2 pins in, movement levels and receive debug out.
// master: key controller side; slave: pins driver / draw_char side.
interface char_key_ctrl_if;
  import ps2_pkg::*;

  logic ps2_clk;
  logic ps2_data;
  logic stepleft;
  logic stepright;
  logic stepjump;
  sc_t  rx_byte;
  logic rx_valid;
  logic rx_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output stepleft,
    output stepright,
    output stepjump,
    output rx_byte,
    output rx_valid,
    output rx_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  stepleft,
    input  stepright,
    input  stepjump,
    input  rx_byte,
    input  rx_valid,
    input  rx_err
  );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin sync, falling-edge detect, 11-bit FSM, watchdog.
// Ports: i_clk/i_rst, i_ps2_clk/i_ps2_data in; o_rx_byte/o_rx_valid/o_rx_err out.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 13000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output sc_t  o_rx_byte,
  output logic o_rx_valid,
  output logic o_rx_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DATA   = DATA;
  localparam logic [1:0] ST_PARITY = PARITY;
  localparam logic [1:0] ST_STOP   = STOP;

  logic           r_c1;
  logic           r_c2;
  logic           r_cp;
  logic           r_d1;
  logic           r_d2;
  logic [1:0]     r_state;
  logic [2:0]     r_cnt;
  sc_t            r_shift;
  logic           r_par;
  logic [WDW-1:0] r_wd;
  sc_t            r_byte;
  logic           r_valid;
  logic           r_err;

  logic w_fall;
  logic w_tmo;

  assign w_fall = r_cp & ~r_c2;
  // Checked before the edge so a coincident edge loses.
  assign w_tmo  = (r_wd == WDW'(TIMEOUT_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c1    <= 1'b1;
      r_c2    <= 1'b1;
      r_cp    <= 1'b1;
      r_d1    <= 1'b1;
      r_d2    <= 1'b1;
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_wd    <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_c1    <= i_ps2_clk;
      r_c2    <= r_c1;
      r_cp    <= r_c2;
      r_d1    <= i_ps2_data;
      r_d2    <= r_d1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_wd <= '0;
        if (w_fall && !r_d2) begin
          r_state <= ST_DATA;
          r_cnt   <= '0;
        end
      end else if (w_tmo) begin
        r_state <= ST_IDLE;
        r_err   <= 1'b1;
        r_wd    <= '0;
      end else if (w_fall) begin
        r_wd <= '0;
        case (r_state)
          ST_DATA: begin
            r_shift <= {r_d2, r_shift[7:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_par   <= r_d2;
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            // Odd parity: data plus parity bit has odd weight.
            if (r_d2 && (^{r_shift, r_par})) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_err   <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end else begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign o_rx_byte  = r_byte;
  assign o_rx_valid = r_valid;
  assign o_rx_err   = r_err;

endmodule

// File: rtl/char_key_ctrl.sv
// PS/2 keyboard to held-key step levels for draw_char.
// Ports: clk, rst; bus (master) carries pins, step levels, rx debug.
module char_key_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 13000
) (
  input logic             clk,
  input logic             rst,
  char_key_ctrl_if.master bus
);

  sc_t             w_byte;
  logic            w_valid;
  logic            w_err;

  logic            r_ext;
  logic            r_brk;
  logic [NKEY-1:0] r_hold;
  logic            r_stepleft;
  logic            r_stepright;
  logic            r_stepjump;

  logic            w_ext_n;
  logic            w_brk_n;
  logic [NKEY-1:0] w_hold_n;
  logic [2:0]      w_idx;
  logic            w_l;
  logic            w_r;
  logic            w_j;

  ps2_rx #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ps2_clk  (bus.ps2_clk),
    .i_ps2_data (bus.ps2_data),
    .o_rx_byte  (w_byte),
    .o_rx_valid (w_valid),
    .o_rx_err   (w_err)
  );

  always_comb begin
    w_ext_n  = r_ext;
    w_brk_n  = r_brk;
    w_hold_n = r_hold;
    w_idx    = key_idx(r_ext, w_byte);
    if (w_err) begin
      w_ext_n = 1'b0;
      w_brk_n = 1'b0;
    end else if (w_valid) begin
      unique case (1'b1)
        (w_byte == SC_EXT): w_ext_n = 1'b1;
        (w_byte == SC_BRK): w_brk_n = 1'b1;
        default: begin
          w_ext_n = 1'b0;
          w_brk_n = 1'b0;
          if (w_idx != K_NONE)
            w_hold_n[w_idx] = ~r_brk;
        end
      endcase
    end
  end

  // Step levels come from next-state holds so they land
  // in the same cycle as the decoder update.
  assign w_l = w_hold_n[K_A] | w_hold_n[K_LA];
  assign w_r = w_hold_n[K_D] | w_hold_n[K_RA];
  assign w_j = w_hold_n[K_W] | w_hold_n[K_SP]
             | w_hold_n[K_UA];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_hold      <= '0;
      r_stepleft  <= 1'b0;
      r_stepright <= 1'b0;
      r_stepjump  <= 1'b0;
    end else begin
      r_ext       <= w_ext_n;
      r_brk       <= w_brk_n;
      r_hold      <= w_hold_n;
      r_stepleft  <= w_l & ~w_r;
      r_stepright <= w_r & ~w_l;
      r_stepjump  <= w_j;
    end
  end

  assign bus.stepleft  = r_stepleft;
  assign bus.stepright = r_stepright;
  assign bus.stepjump  = r_stepjump;
  assign bus.rx_byte   = w_byte;
  assign bus.rx_valid  = w_valid;
  assign bus.rx_err    = w_err;

endmodule

// File: tb/tb_char_key_ctrl.sv
// Self-checking bench for char_key_ctrl: directed table, corner
// sequences and random frames against a key-set reference model.
module tb_char_key_ctrl;

  localparam int T = 200;
  localparam int H = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_key_ctrl_if u_if ();

  char_key_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int valid_cyc = -1;
  int err_cyc = -1;
  int l_rise_cyc = -1;
  int n_valid = 0;
  int n_err = 0;
  logic prev_l = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.rx_valid) begin
      n_valid = n_valid + 1;
      valid_cyc = cyc;
    end
    if (u_if.rx_err) begin
      n_err = n_err + 1;
      err_cyc = cyc;
    end
    if (u_if.stepleft && !prev_l) l_rise_cyc = cyc;
    prev_l = u_if.stepleft;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = bad ? (^b) : ~(^b);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      u_if.ps2_data = bits[i];
      repeat (H) @(negedge clk);
      u_if.ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (H) @(negedge clk);
      u_if.ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(mk_frame(b, bad), 11);
    repeat (4) @(negedge clk);
  endtask

  function automatic int outs();
    return {29'd0, u_if.stepleft, u_if.stepright, u_if.stepjump};
  endfunction

  // Reference: set of held keys indexed by {extended, code}.
  logic [511:0] m_held;
  bit           m_ext;
  bit           m_brk;
  logic [7:0]   m_last;

  task automatic m_reset();
    m_held = '0;
    m_ext = 0;
    m_brk = 0;
    m_last = 8'h00;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_ext = 0;
      m_brk = 0;
    end else begin
      m_last = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        m_held[{m_ext, b}] = !m_brk;
        m_ext = 0;
        m_brk = 0;
      end
    end
  endtask

  function automatic int m_outs();
    bit l, r, j;
    l = m_held[9'h01C] | m_held[9'h16B];
    r = m_held[9'h023] | m_held[9'h174];
    j = m_held[9'h01D] | m_held[9'h029] | m_held[9'h175];
    return {29'd0, l & ~r, r & ~l, j};
  endfunction

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [2:0] exp;
  } vec_t;

  vec_t tbl[33];
  logic [7:0] pool[12];
  logic [10:0] fr;
  int nv0, ne0;

  initial begin
    tbl[0]  = '{8'hF0, 0, 3'b100};
    tbl[1]  = '{8'h1C, 0, 3'b000};
    tbl[2]  = '{8'hE0, 0, 3'b000};
    tbl[3]  = '{8'h74, 0, 3'b010};
    tbl[4]  = '{8'hE0, 0, 3'b010};
    tbl[5]  = '{8'h75, 0, 3'b011};
    tbl[6]  = '{8'hE0, 0, 3'b011};
    tbl[7]  = '{8'hF0, 0, 3'b011};
    tbl[8]  = '{8'h74, 0, 3'b001};
    tbl[9]  = '{8'h1C, 0, 3'b101};
    tbl[10] = '{8'h23, 0, 3'b001};
    tbl[11] = '{8'hF0, 0, 3'b001};
    tbl[12] = '{8'h1C, 0, 3'b011};
    tbl[13] = '{8'hF0, 0, 3'b011};
    tbl[14] = '{8'h23, 0, 3'b001};
    tbl[15] = '{8'h1C, 1, 3'b001};
    tbl[16] = '{8'h1C, 0, 3'b101};
    tbl[17] = '{8'h1C, 0, 3'b101};
    tbl[18] = '{8'hF0, 1, 3'b101};
    tbl[19] = '{8'h1C, 0, 3'b101};
    tbl[20] = '{8'hE0, 0, 3'b101};
    tbl[21] = '{8'hF0, 0, 3'b101};
    tbl[22] = '{8'h75, 0, 3'b100};
    tbl[23] = '{8'hF0, 0, 3'b100};
    tbl[24] = '{8'h1C, 0, 3'b000};
    tbl[25] = '{8'hE0, 0, 3'b000};
    tbl[26] = '{8'h00, 1, 3'b000};
    tbl[27] = '{8'h74, 0, 3'b000};
    tbl[28] = '{8'hE0, 0, 3'b000};
    tbl[29] = '{8'h6B, 0, 3'b100};
    tbl[30] = '{8'hE0, 0, 3'b100};
    tbl[31] = '{8'hF0, 0, 3'b100};
    tbl[32] = '{8'h6B, 0, 3'b000};

    pool = '{8'h1C, 8'h23, 8'h1D, 8'h29, 8'h6B, 8'h74,
             8'h75, 8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h5A};

    u_if.ps2_clk = 1'b1;
    u_if.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_outs", outs(), 0);
    chk("reset_rx_byte", int'(u_if.rx_byte), 0);
    chk("reset_pulses", n_valid + n_err, 0);

    // Make of A with exact latency from the stop-bit edge.
    send_frame(8'h1C, 0);
    chk("lat_rx_valid", valid_cyc - fall_cyc, 3);
    chk("lat_stepleft", l_rise_cyc - fall_cyc, 4);
    chk("lat_rx_byte", int'(u_if.rx_byte), 'h1C);
    chk("lat_outs", outs(), 3'b100);

    foreach (tbl[i]) begin
      nv0 = n_valid;
      ne0 = n_err;
      send_frame(tbl[i].code, tbl[i].bad);
      chk($sformatf("tbl%0d_outs", i), outs(), int'(tbl[i].exp));
      chk($sformatf("tbl%0d_pulses", i),
          (n_valid - nv0) * 16 + (n_err - ne0),
          tbl[i].bad ? 1 : 16);
    end

    // Partial frame then silence: watchdog must fire.
    nv0 = n_valid;
    ne0 = n_err;
    send_bits(mk_frame(8'h29, 0), 5);
    for (int i = 0; i < T + 50; i++) begin
      @(negedge clk);
      if (n_err != ne0) break;
    end
    chk("tmo_err_count", n_err - ne0, 1);
    chk("tmo_valid_count", n_valid - nv0, 0);
    chk("tmo_cycle", err_cyc - fall_cyc, 3 + T);
    send_frame(8'h29, 0);
    chk("tmo_then_space", outs(), 3'b001);
    chk("tmo_then_byte", int'(u_if.rx_byte), 'h29);

    // Reset pulse during bit 4 of a frame.
    fr = mk_frame(8'h23, 0);
    send_bits(fr, 4);
    @(negedge clk);
    u_if.ps2_data = fr[4];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_outs", outs(), 0);
    chk("rstmid_rx_byte", int'(u_if.rx_byte), 0);
    repeat (H) @(negedge clk);
    send_frame(8'h23, 0);
    chk("rstmid_then_d", outs(), 3'b010);
    chk("rstmid_then_byte", int'(u_if.rx_byte), 'h23);

    // Random frames against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < 80; i++) begin
      logic [7:0] b;
      bit bad;
      b = pool[$urandom_range(0, 11)];
      bad = ($urandom_range(0, 7) == 0);
      nv0 = n_valid;
      ne0 = n_err;
      send_frame(b, bad);
      m_byte(b, bad);
      chk($sformatf("rnd%0d_outs", i), outs(), m_outs());
      chk($sformatf("rnd%0d_byte", i), int'(u_if.rx_byte), int'(m_last));
      chk($sformatf("rnd%0d_err", i), n_err - ne0, bad ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
